flash_phy_rd_buf_ctrl: RTL and testbench

//  Command side of the flash read buffers: looks up incoming reads against buffer tags and

---
 rtl/flash_phy_pkg.sv | 40 ++++
 rtl/flash_phy_rd_buf_lru.sv | 81 ++++++++
 rtl/flash_phy_rd_buf_ctrl.sv | 176 +++++++++++++++++
 tb/tb_flash_phy_rd_buf_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/flash_phy_pkg.sv
// Shared types and constants for the flash PHY read-buffer logic.
//
// Contents:
//   BankAddrW      - width of a bank-local flash address
//   InfoTypesWidth - width of the info-page type selector
//   NumBufDefault  - default number of read buffers
//   rd_attr_e      - buffer state: Invalid, Wip (read in flight), Valid
//   rd_buf_t       - per-buffer state as seen by the controller
//   rd_buf_match   - tag compare of one buffer against an address/partition/info type
package flash_phy_pkg;

    localparam int BankAddrW      = 16;
    localparam int InfoTypesWidth = 2;
    localparam int NumBufDefault  = 4;

    typedef enum logic [1:0] {
        RdInvalid = 2'b00,
        RdWip     = 2'b01,
        RdValid   = 2'b10
    } rd_attr_e;

    typedef struct packed {
        rd_attr_e                  attr;
        logic [BankAddrW-1:0]      addr;
        logic                      part;
        logic [InfoTypesWidth-1:0] info_sel;
    } rd_buf_t;

    // An Invalid buffer never matches, whatever its stale tag holds.
    function automatic logic rd_buf_match(
        input rd_buf_t                   b,
        input logic [BankAddrW-1:0]      addr,
        input logic                      part,
        input logic [InfoTypesWidth-1:0] info_sel
    );
        return (b.attr != RdInvalid) && (b.addr == addr) &&
               (b.part == part) && (b.info_sel == info_sel);
    endfunction

endpackage

// File: rtl/flash_phy_rd_buf_lru.sv
// LRU ranking and victim selection for the read buffers.
//
// Ports:
//   clk_i, rst_ni  - clock, async active-low reset
//   clr_i          - return ranks to their index order (buffers disabled)
//   touch_i        - a buffer was hit or allocated this cycle
//   touch_idx_i    - index of the touched buffer
//   invalid_i      - per-buffer Invalid flags
//   valid_i        - per-buffer Valid flags
//   victim_vld_o   - a replaceable buffer exists
//   victim_idx_o   - lowest-index Invalid buffer, else oldest Valid buffer
//
// Rank 0 is most recently used, rank NumBuf-1 least recently used. The ranks
// always form a permutation of 0..NumBuf-1, so the oldest Valid buffer is unique.
module flash_phy_rd_buf_lru
    import flash_phy_pkg::*;
#(
    parameter int NumBuf = NumBufDefault,
    localparam int IdxW  = $clog2(NumBuf)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              touch_i,
    input  logic [IdxW-1:0]   touch_idx_i,
    input  logic [NumBuf-1:0] invalid_i,
    input  logic [NumBuf-1:0] valid_i,
    output logic              victim_vld_o,
    output logic [IdxW-1:0]   victim_idx_o
);

    logic [IdxW-1:0] rank_q [NumBuf];

    logic            inv_found;
    logic [IdxW-1:0] inv_idx;
    logic            val_found;
    logic [IdxW-1:0] val_idx;
    logic [IdxW-1:0] best_rank;

    // Touched buffer moves to rank 0; everything that was younger ages by one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumBuf; i++) rank_q[i] <= IdxW'(i);
        end else if (clr_i) begin
            for (int i = 0; i < NumBuf; i++) rank_q[i] <= IdxW'(i);
        end else if (touch_i) begin
            for (int i = 0; i < NumBuf; i++) begin
                if (IdxW'(i) == touch_idx_i) begin
                    rank_q[i] <= '0;
                end else if (rank_q[i] < rank_q[touch_idx_i]) begin
                    rank_q[i] <= rank_q[i] + 1'b1;
                end
            end
        end
    end

    // Invalid buffers are free and preferred; Wip buffers appear in neither mask.
    always_comb begin
        inv_found    = 1'b0;
        inv_idx      = '0;
        val_found    = 1'b0;
        val_idx      = '0;
        best_rank    = '0;
        for (int i = NumBuf - 1; i >= 0; i--) begin
            if (invalid_i[i]) begin
                inv_found = 1'b1;
                inv_idx   = IdxW'(i);
            end
        end
        for (int i = 0; i < NumBuf; i++) begin
            if (valid_i[i] && (!val_found || (rank_q[i] > best_rank))) begin
                val_found = 1'b1;
                best_rank = rank_q[i];
                val_idx   = IdxW'(i);
            end
        end
        victim_vld_o = inv_found || val_found;
        victim_idx_o = inv_found ? inv_idx : val_idx;
    end

endmodule

// File: rtl/flash_phy_rd_buf_ctrl.sv
// Command side of the flash read buffers.
//
// Looks up incoming reads against the buffer tags, answers hits in the same
// cycle, allocates a victim buffer on a miss and tracks the resulting flash
// reads in order so returning data lands in the buffer allocated for it.
// Program operations wipe every matching buffer.
//
// Ports:
//   clk_i, rst_ni                  - clock, async active-low reset
//   en_i                           - buffer enable; low flushes tracking state
//   req_i, req_addr_i, req_part_i,
//   req_info_sel_i                 - host read request
//   req_ack_o, hit_o, hit_idx_o    - request accepted / hit / buffer index
//   rsp_vld_i                      - flash read data returned
//   prog_i, prog_addr_i,
//   prog_part_i, prog_info_sel_i   - program issued to this location
//   buf_i                          - current state of every buffer
//   alloc_o, update_o, wipe_o      - strobes into the buffer array
//   rsp_orphan_o                   - response with no outstanding read
module flash_phy_rd_buf_ctrl
    import flash_phy_pkg::*;
#(
    parameter int NumBuf       = NumBufDefault,
    parameter int RspFifoDepth = 2,
    localparam int IdxW        = $clog2(NumBuf)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic                       req_i,
    input  logic [BankAddrW-1:0]       req_addr_i,
    input  logic                       req_part_i,
    input  logic [InfoTypesWidth-1:0]  req_info_sel_i,
    output logic                       req_ack_o,
    output logic                       hit_o,
    output logic [IdxW-1:0]            hit_idx_o,
    input  logic                       rsp_vld_i,
    input  logic                       prog_i,
    input  logic [BankAddrW-1:0]       prog_addr_i,
    input  logic                       prog_part_i,
    input  logic [InfoTypesWidth-1:0]  prog_info_sel_i,
    input  rd_buf_t [NumBuf-1:0]       buf_i,
    output logic [NumBuf-1:0]          alloc_o,
    output logic [NumBuf-1:0]          update_o,
    output logic [NumBuf-1:0]          wipe_o,
    output logic                       rsp_orphan_o
);

    localparam int PtrW = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    localparam int CntW = $clog2(RspFifoDepth + 1);

    // A dead entry belongs to a buffer wiped while its read was in flight.
    typedef struct packed {
        logic            dead;
        logic [IdxW-1:0] idx;
    } fifo_entry_t;

    fifo_entry_t     fifo_q [RspFifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;

    logic [NumBuf-1:0] req_match, prog_match;
    logic [NumBuf-1:0] valid_mask, wip_mask, invalid_mask;
    logic [NumBuf-1:0] hit_vec;
    logic              wip_hit;
    logic [IdxW-1:0]   hit_sel;
    logic              victim_vld;
    logic [IdxW-1:0]   victim_idx;
    logic              fifo_empty, fifo_full;
    fifo_entry_t       head;
    logic              head_dead;
    logic              req_ok, do_hit, do_alloc, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspFifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Tag lookups for the read request and the program operation.
    always_comb begin
        req_match    = '0;
        prog_match   = '0;
        valid_mask   = '0;
        wip_mask     = '0;
        invalid_mask = '0;
        for (int b = 0; b < NumBuf; b++) begin
            req_match[b]    = rd_buf_match(buf_i[b], req_addr_i, req_part_i, req_info_sel_i);
            prog_match[b]   = rd_buf_match(buf_i[b], prog_addr_i, prog_part_i, prog_info_sel_i);
            valid_mask[b]   = (buf_i[b].attr == RdValid);
            wip_mask[b]     = (buf_i[b].attr == RdWip);
            invalid_mask[b] = (buf_i[b].attr == RdInvalid);
        end
    end

    // Lowest-index Valid match; more than one should never occur.
    always_comb begin
        hit_vec = req_match & valid_mask;
        wip_hit = |(req_match & wip_mask);
        hit_sel = '0;
        for (int b = NumBuf - 1; b >= 0; b--) begin
            if (hit_vec[b]) hit_sel = IdxW'(b);
        end
    end

    flash_phy_rd_buf_lru #(
        .NumBuf (NumBuf)
    ) u_lru (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (!en_i),
        .touch_i      (do_hit || do_alloc),
        .touch_idx_i  (hit_idx_o),
        .invalid_i    (invalid_mask),
        .valid_i      (valid_mask),
        .victim_vld_o (victim_vld),
        .victim_idx_o (victim_idx)
    );

    // Request and response decisions. A response pops first, so a full FIFO
    // can still accept an allocation in the same cycle. A head whose buffer is
    // being wiped this very cycle is treated as dead already.
    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CntW'(RspFifoDepth));
        head       = fifo_q[rd_ptr_q];
        head_dead  = head.dead || (prog_i && prog_match[head.idx]);
        pop        = en_i && rsp_vld_i && !fifo_empty;

        req_ok   = en_i && req_i && !prog_i;
        do_hit   = req_ok && (|hit_vec);
        do_alloc = req_ok && !(|hit_vec) && !wip_hit && victim_vld && (!fifo_full || pop);
        push     = do_alloc;

        req_ack_o    = do_hit || do_alloc;
        hit_o        = do_hit;
        hit_idx_o    = do_hit ? hit_sel : (do_alloc ? victim_idx : '0);
        alloc_o      = do_alloc ? (NumBuf'(1'b1) << victim_idx) : '0;
        update_o     = (pop && !head_dead) ? (NumBuf'(1'b1) << head.idx) : '0;
        wipe_o       = (en_i && prog_i) ? prog_match : '0;
        rsp_orphan_o = rsp_vld_i && (!en_i || fifo_empty);
    end

    // In-flight read FIFO. Disabling the buffers drops every tracked read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < RspFifoDepth; s++) fifo_q[s] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (!en_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int s = 0; s < RspFifoDepth; s++) begin
                if (prog_i && prog_match[fifo_q[s].idx]) fifo_q[s].dead <= 1'b1;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= '{dead: 1'b0, idx: victim_idx};
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    a_alloc_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(alloc_o));
    a_update_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(update_o));
    a_update_to_wip: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (update_o & ~wip_mask) == '0);
    a_no_alloc_wip: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (alloc_o & wip_mask) == '0);

endmodule

// File: tb/tb_flash_phy_rd_buf_ctrl.sv
// Self-checking bench for flash_phy_rd_buf_ctrl with NumBuf=4, RspFifoDepth=2.
// The buffer array is modelled in the bench: alloc makes a buffer Wip with the
// request tag, update makes it Valid, wipe makes it Invalid. Expected strobes
// are hand-computed per vector.
module tb_flash_phy_rd_buf_ctrl;
    import flash_phy_pkg::*;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic                      en_i = 1'b0;
    logic                      req_i = 1'b0;
    logic [BankAddrW-1:0]      req_addr_i = '0;
    logic                      req_part_i = 1'b0;
    logic [InfoTypesWidth-1:0] req_info_sel_i = '0;
    logic                      req_ack_o;
    logic                      hit_o;
    logic [1:0]                hit_idx_o;
    logic                      rsp_vld_i = 1'b0;
    logic                      prog_i = 1'b0;
    logic [BankAddrW-1:0]      prog_addr_i = '0;
    logic                      prog_part_i = 1'b0;
    logic [InfoTypesWidth-1:0] prog_info_sel_i = '0;
    rd_buf_t [3:0]             bufs;
    logic [3:0]                alloc_o, update_o, wipe_o;
    logic                      rsp_orphan_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    flash_phy_rd_buf_ctrl #(
        .NumBuf       (4),
        .RspFifoDepth (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .en_i            (en_i),
        .req_i           (req_i),
        .req_addr_i      (req_addr_i),
        .req_part_i      (req_part_i),
        .req_info_sel_i  (req_info_sel_i),
        .req_ack_o       (req_ack_o),
        .hit_o           (hit_o),
        .hit_idx_o       (hit_idx_o),
        .rsp_vld_i       (rsp_vld_i),
        .prog_i          (prog_i),
        .prog_addr_i     (prog_addr_i),
        .prog_part_i     (prog_part_i),
        .prog_info_sel_i (prog_info_sel_i),
        .buf_i           (bufs),
        .alloc_o         (alloc_o),
        .update_o        (update_o),
        .wipe_o          (wipe_o),
        .rsp_orphan_o    (rsp_orphan_o)
    );

    typedef struct {
        logic        en, req;
        logic [15:0] addr;
        logic        part, rsp, prog;
        logic [15:0] paddr;
        logic        ack, hit;
        logic [1:0]  idx;
        logic [3:0]  alloc, update, wipe;
        logic        orphan;
    } vec_t;

    function automatic vec_t mk(
        input logic en, input logic req, input logic [15:0] addr, input logic part,
        input logic rsp, input logic prog, input logic [15:0] paddr,
        input logic ack, input logic hit, input logic [1:0] idx,
        input logic [3:0] alloc, input logic [3:0] update, input logic [3:0] wipe,
        input logic orphan
    );
        vec_t v;
        v.en = en; v.req = req; v.addr = addr; v.part = part;
        v.rsp = rsp; v.prog = prog; v.paddr = paddr;
        v.ack = ack; v.hit = hit; v.idx = idx;
        v.alloc = alloc; v.update = update; v.wipe = wipe; v.orphan = orphan;
        return v;
    endfunction

    task automatic check_output(input vec_t v, input string name);
        logic [16:0] act, exp;
        act = {req_ack_o, hit_o, hit_idx_o, alloc_o, update_o, wipe_o, rsp_orphan_o};
        exp = {v.ack, v.hit, v.idx, v.alloc, v.update, v.wipe, v.orphan};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: ack/hit/idx/alloc/upd/wipe/orph got %b/%b/%0d/%b/%b/%b/%b want %b/%b/%0d/%b/%b/%b/%b",
                      name, req_ack_o, hit_o, hit_idx_o, alloc_o, update_o, wipe_o, rsp_orphan_o,
                      v.ack, v.hit, v.idx, v.alloc, v.update, v.wipe, v.orphan);
    endtask

    // Drive one cycle, compare on the falling edge, then let the buffer model
    // react to the strobes just after the rising edge.
    task automatic apply_stimulus(input vec_t v, input string name);
        logic [3:0]  a, u, w;
        logic [15:0] ad;
        logic        pt;
        en_i = v.en; req_i = v.req; req_addr_i = v.addr; req_part_i = v.part;
        rsp_vld_i = v.rsp; prog_i = v.prog; prog_addr_i = v.paddr;
        @(negedge clk_i);
        check_output(v, name);
        a = alloc_o; u = update_o; w = wipe_o; ad = req_addr_i; pt = req_part_i;
        @(posedge clk_i);
        #1;
        for (int b = 0; b < 4; b++) begin
            if (u[b]) bufs[b].attr = RdValid;
            if (w[b]) bufs[b].attr = RdInvalid;
            if (a[b]) begin
                bufs[b].attr = RdWip; bufs[b].addr = ad;
                bufs[b].part = pt;    bufs[b].info_sel = '0;
            end
        end
    endtask

    task automatic set_all(input rd_attr_e attr, input logic [15:0] base);
        for (int b = 0; b < 4; b++) begin
            bufs[b].attr = attr; bufs[b].addr = base + 16'(b);
            bufs[b].part = 1'b0; bufs[b].info_sel = '0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        set_all(RdInvalid, 16'h0);

        //              en req addr    pt rsp prg paddr    ack hit idx alloc    update   wipe     orph
        tbl.push_back(mk(1, 0, 16'h00, 0, 0, 0, 16'h00,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0)); // idle after reset
        tbl.push_back(mk(1, 1, 16'h10, 0, 0, 0, 16'h00,  1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0)); // miss -> buf0
        tbl.push_back(mk(1, 1, 16'h10, 0, 0, 0, 16'h00,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0)); // wip match stalls
        tbl.push_back(mk(1, 0, 16'h00, 0, 1, 0, 16'h00,  0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0)); // data -> buf0
        tbl.push_back(mk(1, 1, 16'h10, 0, 0, 0, 16'h00,  1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0)); // hit buf0
        tbl.push_back(mk(1, 1, 16'h10, 1, 0, 0, 16'h00,  1, 0, 1, 4'b0010, 4'b0000, 4'b0000, 0)); // part differs -> buf1
        tbl.push_back(mk(1, 1, 16'h20, 0, 1, 0, 16'h00,  1, 0, 2, 4'b0100, 4'b0010, 4'b0000, 0)); // push+pop
        tbl.push_back(mk(1, 1, 16'h30, 0, 0, 0, 16'h00,  1, 0, 3, 4'b1000, 4'b0000, 4'b0000, 0)); // fifo now full
        tbl.push_back(mk(1, 1, 16'h40, 0, 0, 0, 16'h00,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0)); // full -> stall
        tbl.push_back(mk(1, 1, 16'h40, 0, 1, 0, 16'h00,  1, 0, 0, 4'b0001, 4'b0100, 4'b0000, 0)); // pop frees slot, LRU buf0
        tbl.push_back(mk(1, 1, 16'h20, 0, 0, 1, 16'h30,  0, 0, 0, 4'b0000, 4'b0000, 4'b1000, 0)); // wipe wip buf3
        tbl.push_back(mk(1, 0, 16'h00, 0, 1, 0, 16'h00,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0)); // dead entry dropped
        tbl.push_back(mk(1, 1, 16'h20, 0, 0, 0, 16'h00,  1, 1, 2, 4'b0000, 4'b0000, 4'b0000, 0)); // hit buf2
        tbl.push_back(mk(1, 0, 16'h00, 0, 0, 1, 16'h20,  0, 0, 0, 4'b0000, 4'b0000, 4'b0100, 0)); // wipe valid buf2
        tbl.push_back(mk(1, 0, 16'h00, 0, 1, 0, 16'h00,  0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0)); // data -> buf0
        tbl.push_back(mk(1, 0, 16'h00, 0, 1, 0, 16'h00,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1)); // orphan
        tbl.push_back(mk(1, 1, 16'h50, 0, 0, 0, 16'h00,  1, 0, 2, 4'b0100, 4'b0000, 4'b0000, 0)); // lowest invalid buf2
        tbl.push_back(mk(0, 1, 16'h10, 1, 0, 0, 16'h00,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0)); // disabled
        tbl.push_back(mk(1, 0, 16'h00, 0, 1, 0, 16'h00,  0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1)); // flushed read -> orphan

        #12 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < tbl.size(); i++)
            apply_stimulus(tbl[i], $sformatf("vec%0d", i));

        // LRU: touch 3,2,1,0 so buf3 is oldest, then buf2 after buf3 is reused.
        set_all(RdValid, 16'h100);
        apply_stimulus(mk(0, 0, 16'h000, 0, 0, 0, 16'h0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0), "lru_clr");
        apply_stimulus(mk(1, 1, 16'h103, 0, 0, 0, 16'h0, 1, 1, 3, 4'b0000, 4'b0000, 4'b0000, 0), "lru_hit3");
        apply_stimulus(mk(1, 1, 16'h102, 0, 0, 0, 16'h0, 1, 1, 2, 4'b0000, 4'b0000, 4'b0000, 0), "lru_hit2");
        apply_stimulus(mk(1, 1, 16'h101, 0, 0, 0, 16'h0, 1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0), "lru_hit1");
        apply_stimulus(mk(1, 1, 16'h100, 0, 0, 0, 16'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0), "lru_hit0");
        apply_stimulus(mk(1, 1, 16'h200, 0, 0, 0, 16'h0, 1, 0, 3, 4'b1000, 4'b0000, 4'b0000, 0), "lru_victim3");
        apply_stimulus(mk(1, 0, 16'h000, 0, 1, 0, 16'h0, 0, 0, 0, 4'b0000, 4'b1000, 4'b0000, 0), "lru_fill3");
        apply_stimulus(mk(1, 1, 16'h201, 0, 0, 0, 16'h0, 1, 0, 2, 4'b0100, 4'b0000, 4'b0000, 0), "lru_victim2");
        apply_stimulus(mk(1, 0, 16'h000, 0, 1, 0, 16'h0, 0, 0, 0, 4'b0000, 4'b0100, 4'b0000, 0), "lru_fill2");

        // All buffers Wip: a miss has no victim; a program still wipes a Wip buffer.
        set_all(RdWip, 16'h300);
        apply_stimulus(mk(1, 1, 16'h400, 0, 0, 0, 16'h000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0), "all_wip_stall");
        apply_stimulus(mk(0, 0, 16'h000, 0, 0, 0, 16'h000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0), "all_wip_clr");
        apply_stimulus(mk(1, 0, 16'h000, 0, 0, 1, 16'h301, 0, 0, 0, 4'b0000, 4'b0000, 4'b0010, 0), "wipe_wip1");
        apply_stimulus(mk(1, 1, 16'h400, 0, 0, 0, 16'h000, 1, 0, 1, 4'b0010, 4'b0000, 4'b0000, 0), "alloc_freed1");

        // Asynchronous reset mid-cycle drops the outstanding read.
        #2 rst_ni = 1'b0;
        #1 rst_ni = 1'b1;
        apply_stimulus(mk(1, 0, 16'h000, 0, 1, 0, 16'h000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1), "reset_orphan");

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
